traffic_gen_mc: RTL

Parametrised multi-channel packet traffic generator. It supersedes the two-channel UL/DL generator by supporting NUM_CH independent LFSR-driven ID streams. A period counter paces packet creation. A round-robin or burst arbiter picks the source channel for each packet, and a registered valid/ready output port holds each packet until the consumer accepts it. Overrun is detected and counted, not silently overwritten; the block sits between the top-level pin wrapper and any downstream packet sink or checker.

---
 rtl/traffic_gen_mc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/traffic_gen_mc.sv
// traffic_gen_mc
//   Multi-channel packet traffic generator. Each of NUM_CH channels owns an
//   LFSR that supplies packet IDs. A period counter opens one packet slot every
//   period+1 cycles. A round-robin or burst arbiter picks the channel for the
//   slot. The packet is held on a registered valid/ready port until the
//   consumer accepts it. A slot that finds the port still occupied is counted
//   as a drop, and the held packet is left untouched.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   rst_n       in   asynchronous active-low reset
//   period      in   slot spacing, one slot every period+1 cycles
//   ch_enable   in   per-channel grant enable
//   burst_mode  in   0 = round-robin, 1 = burst
//   burst_len   in   packets per burst grant minus 1
//   out_valid   out  packet present on out_id/out_ch
//   out_ready   in   consumer accepts when out_valid && out_ready
//   out_id      out  packet ID (LFSR value of the granted channel)
//   out_ch      out  source channel index
//   pkt_cnt     out  packets issued, wraps
//   drop_cnt    out  slots lost to backpressure, saturating
module traffic_gen_mc #(
  parameter int unsigned      NUM_CH    = 4,
  parameter int unsigned      ID_W      = 8,
  parameter int unsigned      PERIOD_W  = 4,
  parameter int unsigned      BURST_W   = 3,
  parameter logic [ID_W-1:0]  TAPS      = 8'hB4,
  parameter logic [ID_W-1:0]  SEED_BASE = 8'hAA,
  parameter logic [ID_W-1:0]  SEED_STEP = 8'h11,
  localparam int unsigned     CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                burst_mode,
  input  logic [BURST_W-1:0]  burst_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic [CH_W-1:0]     out_ch,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         drop_cnt
);

  // Seed of channel k; an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [ID_W-1:0] seed_of(input int unsigned k);
    logic [ID_W-1:0] s;
    s = SEED_BASE + ID_W'(k) * SEED_STEP;
    if (s == '0) s = ID_W'(1);
    return s;
  endfunction

  function automatic logic [ID_W-1:0] lfsr_next(input logic [ID_W-1:0] v);
    return {v[ID_W-2:0], ^(v & TAPS)};
  endfunction

  logic [PERIOD_W-1:0] cnt;
  logic [CH_W-1:0]     last;
  logic [BURST_W-1:0]  bcnt;
  logic                held;   // last issue was a burst-mode grant
  logic [ID_W-1:0]     lfsr [NUM_CH];

  logic                tick;
  logic                any_en;
  logic                stall;
  logic                issue;
  logic                drop;
  logic [CH_W-1:0]     rr_g;
  logic                stay;
  logic [CH_W-1:0]     g;

  assign tick   = (cnt >= period);
  assign any_en = |ch_enable;
  assign stall  = out_valid && !out_ready;
  assign issue  = tick && any_en && !stall;
  assign drop   = tick && any_en && stall;

  // First enabled channel searching last+1, last+2, ... with wrap.
  always_comb begin
    rr_g = last;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      int unsigned idx;
      idx = (32'(last) + i) % NUM_CH;
      if (ch_enable[CH_W'(idx)]) rr_g = CH_W'(idx);
    end
  end

  // A burst only continues if the previous grant was itself a burst grant,
  // so the first burst after reset or after a mode switch starts at the next
  // round-robin channel instead of extending the reset value of last.
  assign stay = burst_mode && held && ch_enable[last] && (bcnt < burst_len);
  assign g    = stay ? last : rr_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      last      <= CH_W'(NUM_CH - 1);
      bcnt      <= '0;
      held      <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_ch    <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) lfsr[k] <= seed_of(k);
    end else begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;

      if (issue) begin
        out_valid <= 1'b1;
        out_id    <= lfsr[g];
        out_ch    <= g;
        lfsr[g]   <= lfsr_next(lfsr[g]);
        pkt_cnt   <= pkt_cnt + 16'd1;
        last      <= g;
        bcnt      <= stay ? bcnt + 1'b1 : '0;
        held      <= burst_mode;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
